// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of the decode/hazard signals exchanged between the
// pipeline datapath and the hazard controller.
//   master : the datapath side, drives the ID/EX/MEM status, reads the controls
//   slave  : the hazard controller, reads the status, drives the controls
// Status   : ID_Rs, ID_Rt, ID_UsesRt, ID_ReadsHiLo, EXmemread, EX2016Inst,
//            EXIsMul, MEMBrTaken
// Controls : PCWrite, IFIDWrite, IFIDFlush, Hazard, EXMEMFlush, State,
//            StallCnt, FlushCnt
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             ID_ReadsHiLo;
  logic             EXmemread;
  logic [4:0]       EX2016Inst;
  logic             EXIsMul;
  logic             MEMBrTaken;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             Hazard;
  logic             EXMEMFlush;
  logic [1:0]       State;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_ReadsHiLo, EXmemread, EX2016Inst,
           EXIsMul, MEMBrTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, Hazard, EXMEMFlush, State,
           StallCnt, FlushCnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_ReadsHiLo, EXmemread, EX2016Inst,
           EXIsMul, MEMBrTaken,
    output PCWrite, IFIDWrite, IFIDFlush, Hazard, EXMEMFlush, State,
           StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for a 5-stage pipeline whose branches and
// jumps resolve in MEM. Decides each cycle between flush, load-use stall,
// HI/LO-after-multiply stall and normal run, and keeps saturating stall and
// flush counters.
// Ports:
//   Clk  : clock, all state updates on posedge
//   Rst  : synchronous reset, active-low
//   bus  : hazard_ctrl_if.slave (status in, pipeline controls/State/counters out)
// Pipeline controls are combinational from the status inputs and the
// registered multiply counter, so they act at the coming edge.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input logic          Clk,
  input logic          Rst,
  hazard_ctrl_if.slave bus
);

  localparam int MW = ($clog2(MUL_LAT) > 3) ? $clog2(MUL_LAT) : 3;
  // Cycles still to wait after the mul leaves EX; 0 when MUL_LAT is 1.
  localparam logic [MW-1:0] MUL_LOAD = MW'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LDSTALL  = 2'd1,
    ST_MULSTALL = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [MW-1:0]    mul_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             lu_s;
  logic             mi_s;
  logic             pc_write_s;
  logic             ifid_write_s;
  logic             ifid_flush_s;
  logic             hazard_s;
  logic             exmem_flush_s;

  // A load to $0 never creates a dependency, so a zero destination is excluded.
  assign lu_s = bus.EXmemread && (bus.EX2016Inst != 5'd0) &&
                ((bus.EX2016Inst == bus.ID_Rs) ||
                 (bus.ID_UsesRt && (bus.EX2016Inst == bus.ID_Rt)));

  assign mi_s = (mul_cnt_r != {MW{1'b0}}) && bus.ID_ReadsHiLo;

  // State register: remembers which action was taken last cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode, branch flush has priority over both stall kinds.
  always_comb begin
    state_nxt_s = ST_RUN;
    if (bus.MEMBrTaken) begin
      state_nxt_s = ST_FLUSH;
    end else if (lu_s) begin
      state_nxt_s = ST_LDSTALL;
    end else if (mi_s) begin
      state_nxt_s = ST_MULSTALL;
    end else begin
      state_nxt_s = ST_RUN;
    end
  end

  // Output decode of the chosen action; reset squashes the whole pipeline.
  always_comb begin
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    hazard_s      = 1'b0;
    exmem_flush_s = 1'b0;
    if (!Rst) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      ifid_flush_s  = 1'b1;
      hazard_s      = 1'b1;
      exmem_flush_s = 1'b1;
    end else begin
      case (state_nxt_s)
        ST_FLUSH: begin
          // PC still writes: it takes the branch target.
          ifid_flush_s  = 1'b1;
          hazard_s      = 1'b1;
          exmem_flush_s = 1'b1;
        end
        ST_LDSTALL, ST_MULSTALL: begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          hazard_s     = 1'b1;
        end
        default: begin
          pc_write_s   = 1'b1;
          ifid_write_s = 1'b1;
        end
      endcase
    end
  end

  // HI/LO busy counter; a flush kills the mul in EX, so it clears the count.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      mul_cnt_r <= {MW{1'b0}};
    end else if (bus.MEMBrTaken) begin
      mul_cnt_r <= {MW{1'b0}};
    end else if (bus.EXIsMul) begin
      mul_cnt_r <= MUL_LOAD;
    end else if (mul_cnt_r != {MW{1'b0}}) begin
      mul_cnt_r <= mul_cnt_r - {{(MW-1){1'b0}}, 1'b1};
    end else begin
      mul_cnt_r <= mul_cnt_r;
    end
  end

  // Performance counters; reset cycles are never counted.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bus.MEMBrTaken) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.PCWrite    = pc_write_s;
  assign bus.IFIDWrite  = ifid_write_s;
  assign bus.IFIDFlush  = ifid_flush_s;
  assign bus.Hazard     = hazard_s;
  assign bus.EXMEMFlush = exmem_flush_s;
  assign bus.State      = state_r;
  assign bus.StallCnt   = stall_cnt_r;
  assign bus.FlushCnt   = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl (MUL_LAT=4, CNT_W=4
// so counter saturation is reachable quickly). Control outputs are compared
// as the packed vector {PCWrite, IFIDWrite, IFIDFlush, Hazard, EXMEMFlush}.
module tb_hazard_ctrl;

  localparam int CW = 4;

  localparam logic [4:0] O_RESET = 5'b00111;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11111;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(.MUL_LAT(4), .CNT_W(CW)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {hif.PCWrite, hif.IFIDWrite, hif.IFIDFlush, hif.Hazard, hif.EXMEMFlush};
  endfunction

  task automatic idle();
    hif.ID_Rs        = 5'd0;
    hif.ID_Rt        = 5'd0;
    hif.ID_UsesRt    = 1'b0;
    hif.ID_ReadsHiLo = 1'b0;
    hif.EXmemread    = 1'b0;
    hif.EX2016Inst   = 5'd0;
    hif.EXIsMul      = 1'b0;
    hif.MEMBrTaken   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    settle();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b0;
    idle();

    // Reset cycle squashes the pipeline, then idle run
    tick();
    check_val("reset_outs", 32'(outs()), 32'(O_RESET));
    rst = 1'b1;
    settle();
    check_val("post_reset_outs", 32'(outs()), 32'(O_RUN));
    check_val("post_reset_state", 32'(hif.State), 32'd0);
    check_val("post_reset_stall", 32'(hif.StallCnt), 32'd0);
    check_val("post_reset_flush", 32'(hif.FlushCnt), 32'd0);

    // Load-use on rs: one stall cycle
    hif.EXmemread = 1'b1; hif.EX2016Inst = 5'd5; hif.ID_Rs = 5'd5;
    settle();
    check_val("lu_rs_outs", 32'(outs()), 32'(O_STALL));
    tick();
    idle();
    settle();
    check_val("lu_after_outs", 32'(outs()), 32'(O_RUN));
    check_val("lu_state", 32'(hif.State), 32'd1);
    check_val("lu_stallcnt", 32'(hif.StallCnt), 32'd1);
    tick();
    check_val("lu_state_back", 32'(hif.State), 32'd0);

    // Rt only matters when the instruction reads rt
    hif.EXmemread = 1'b1; hif.EX2016Inst = 5'd7; hif.ID_Rt = 5'd7; hif.ID_Rs = 5'd3;
    settle();
    check_val("rt_unused_outs", 32'(outs()), 32'(O_RUN));
    hif.ID_UsesRt = 1'b1;
    settle();
    check_val("rt_used_outs", 32'(outs()), 32'(O_STALL));
    tick();
    idle();
    hif.EXmemread = 1'b1; hif.EX2016Inst = 5'd0; hif.ID_Rs = 5'd0;
    settle();
    check_val("zero_reg_outs", 32'(outs()), 32'(O_RUN));
    check_val("rt_stallcnt", 32'(hif.StallCnt), 32'd2);
    tick();
    idle();

    // Taken branch
    hif.MEMBrTaken = 1'b1;
    settle();
    check_val("br_outs", 32'(outs()), 32'(O_FLUSH));
    tick();
    idle();
    settle();
    check_val("br_state", 32'(hif.State), 32'd3);
    check_val("br_flushcnt", 32'(hif.FlushCnt), 32'd1);

    // Branch together with a load-use: flush wins, no stall counted
    hif.MEMBrTaken = 1'b1; hif.EXmemread = 1'b1; hif.EX2016Inst = 5'd5; hif.ID_Rs = 5'd5;
    settle();
    check_val("br_lu_outs", 32'(outs()), 32'(O_FLUSH));
    tick();
    idle();
    settle();
    check_val("br_lu_state", 32'(hif.State), 32'd3);
    check_val("br_lu_flushcnt", 32'(hif.FlushCnt), 32'd2);
    check_val("br_lu_stallcnt", 32'(hif.StallCnt), 32'd2);

    // Mul interlock: 3 stall cycles behind a multiply
    do_reset();
    hif.EXIsMul = 1'b1;
    settle();
    check_val("mul_issue_outs", 32'(outs()), 32'(O_RUN));
    tick();
    hif.EXIsMul = 1'b0; hif.ID_ReadsHiLo = 1'b1;
    settle();
    check_val("mi_c1_outs", 32'(outs()), 32'(O_STALL));
    check_val("mi_c1_state", 32'(hif.State), 32'd0);
    tick();
    check_val("mi_c2_outs", 32'(outs()), 32'(O_STALL));
    check_val("mi_c2_state", 32'(hif.State), 32'd2);
    tick();
    check_val("mi_c3_outs", 32'(outs()), 32'(O_STALL));
    tick();
    check_val("mi_c4_outs", 32'(outs()), 32'(O_RUN));
    check_val("mi_stallcnt", 32'(hif.StallCnt), 32'd3);
    tick();
    check_val("mi_state_back", 32'(hif.State), 32'd0);
    check_val("mi_stallcnt_hold", 32'(hif.StallCnt), 32'd3);

    // Branch flush during a mul stall clears the interlock
    do_reset();
    hif.EXIsMul = 1'b1;
    tick();
    hif.EXIsMul = 1'b0; hif.ID_ReadsHiLo = 1'b1;
    settle();
    check_val("mibr_c1_outs", 32'(outs()), 32'(O_STALL));
    tick();
    hif.MEMBrTaken = 1'b1;
    settle();
    check_val("mibr_c2_outs", 32'(outs()), 32'(O_FLUSH));
    tick();
    hif.MEMBrTaken = 1'b0;
    settle();
    check_val("mibr_c3_outs", 32'(outs()), 32'(O_RUN));
    check_val("mibr_state", 32'(hif.State), 32'd3);
    check_val("mibr_stallcnt", 32'(hif.StallCnt), 32'd1);
    check_val("mibr_flushcnt", 32'(hif.FlushCnt), 32'd1);

    // Reset in the middle of a mul stall
    do_reset();
    hif.EXIsMul = 1'b1;
    tick();
    hif.EXIsMul = 1'b0; hif.ID_ReadsHiLo = 1'b1;
    settle();
    check_val("rms_stall_outs", 32'(outs()), 32'(O_STALL));
    tick();
    rst = 1'b0;
    settle();
    check_val("rms_reset_outs", 32'(outs()), 32'(O_RESET));
    tick();
    rst = 1'b1;
    settle();
    check_val("rms_hilo_outs", 32'(outs()), 32'(O_RUN));
    check_val("rms_state", 32'(hif.State), 32'd0);
    check_val("rms_stallcnt", 32'(hif.StallCnt), 32'd0);
    check_val("rms_flushcnt", 32'(hif.FlushCnt), 32'd0);
    idle();
    settle();
    check_val("rms_idle_outs", 32'(outs()), 32'(O_RUN));

    // Held load-use stall saturates StallCnt at 15
    do_reset();
    hif.EXmemread = 1'b1; hif.EX2016Inst = 5'd9; hif.ID_Rs = 5'd9;
    settle();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check_val("sat_14", 32'(hif.StallCnt), 32'd14);
      if (i == 15) check_val("sat_15", 32'(hif.StallCnt), 32'd15);
    end
    check_val("sat_20", 32'(hif.StallCnt), 32'd15);
    check_val("sat_outs", 32'(outs()), 32'(O_STALL));
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage pipeline; branches and jumps resolve in MEM.
- Sequences the ID/EX register's Hazard (bubble) input and the PC / IF-ID write enables. Also generates flush strobes for IF/ID and EX/MEM.
- Handles three cases: load-use stalls, flushes on taken branch/jump from MEM, and a multi-cycle HI/LO interlock behind multiply.
- Keeps saturating stall and flush performance counters.

Parameters:
- MUL_LAT, 4: cycles a multiply occupies before HI/LO is readable (minimum 1).
- CNT_W, 32: width of the performance counters.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous reset, active-low. Sampled on posedge Clk.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo.
- EXmemread  in  1  instruction in EX is a load.
- EX2016Inst  in  5  rt (load destination) of the EX instruction.
- EXIsMul  in  1  instruction in EX is a multiply (valid, not a bubble).
- MEMBrTaken  in  1  taken branch or jump resolved in MEM this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register update enable.
- IFIDFlush  out  1  zero IF/ID at the next edge.
- Hazard  out  1  to ID/EX; 1 loads a bubble at the next edge.
- EXMEMFlush  out  1  zero EX/MEM control at the next edge.
- State  out  2  FSM state: 0 RUN, 1 LDSTALL, 2 MULSTALL, 3 FLUSH.
- StallCnt  out  CNT_W  cycles spent with PCWrite=0.
- FlushCnt  out  CNT_W  number of flush events.

Behaviour:
- Conditions are evaluated combinationally every cycle. Decode outputs are combinational from inputs plus the registered mul counter, so they take effect at the same edge.
- Load-use condition (lu): EXmemread=1, EX2016Inst != 0, and either EX2016Inst == ID_Rs or (ID_UsesRt=1 and EX2016Inst == ID_Rt).
- Mul interlock (mi): MulCnt != 0 and ID_ReadsHiLo=1.
- MulCnt is a 3+ bit down-counter, sized for MUL_LAT. Each edge:
  - MEMBrTaken=1: MulCnt <= 0. The flush kills the younger mul in EX.
  - else EXIsMul=1: MulCnt <= MUL_LAT-1.
  - else if MulCnt != 0: MulCnt decrements.
  - With MUL_LAT=1, MulCnt is never loaded and mi never asserts.
- Action priority: MEMBrTaken > lu > mi > none.
  - MEMBrTaken: PCWrite=1 (PC takes target), IFIDWrite=1, IFIDFlush=1, Hazard=1, EXMEMFlush=1. Next State=FLUSH.
  - lu: PCWrite=0, IFIDWrite=0, Hazard=1, flushes 0. Next State=LDSTALL.
  - mi: PCWrite=0, IFIDWrite=0, Hazard=1, flushes 0. Next State=MULSTALL.
  - none: PCWrite=1, IFIDWrite=1, Hazard=0, flushes 0. Next State=RUN.
- State is registered and reports the action taken in the previous cycle. It is observational only and does not gate decode.
- A load-use stall lasts exactly 1 cycle: the next cycle EX holds a bubble with EXmemread=0.
- A mul stall lasts until MulCnt reaches 0. If EXIsMul stays high (back-to-back muls), the counter reloads.
- Counters saturate at all-ones; they never wrap.
  - StallCnt += 1 on each edge where PCWrite=0.
  - FlushCnt += 1 on each edge where MEMBrTaken=1.
- Simultaneous MEMBrTaken and lu: flush only. StallCnt is not incremented and the stall is discarded.
- Reset (Rst=0 at posedge): State=RUN, MulCnt=0, StallCnt=0, FlushCnt=0.
  - During the reset cycle, outputs are forced to PCWrite=0, IFIDWrite=0, IFIDFlush=1, Hazard=1, EXMEMFlush=1. This squashes the pipeline.
  - Reset overrides all conditions, including a stall in progress.
  - Counters do not count reset cycles.
- ID_Rs=0 or ID_Rt=0 never matches, because a load to $0 is excluded.

Test Plan:
- Load-use: EXmemread=1, EX2016Inst=5, ID_Rs=5 for one cycle, then EXmemread=0 → PCWrite=0, IFIDWrite=0, Hazard=1 for exactly 1 cycle; State=1 next cycle; StallCnt=1.
- Rt gating: EX2016Inst=7, ID_Rt=7, ID_UsesRt=0 → no stall; with ID_UsesRt=1 → stall. EX2016Inst=0, ID_Rs=0 → no stall.
- Taken branch: MEMBrTaken=1 for one cycle → IFIDFlush=1, Hazard=1, EXMEMFlush=1, PCWrite=1; State=3; FlushCnt=1. The same cycle with an lu condition → identical outputs, StallCnt unchanged.
- Mul interlock, MUL_LAT=4: EXIsMul=1 for one cycle, then ID_ReadsHiLo=1 held → PCWrite=0 for 3 cycles, then 1; StallCnt=3. A branch flush on cycle 2 → MulCnt=0, stall ends immediately.
- Reset mid-stall: assert Rst=0 during a mul stall → outputs take their reset values that cycle. After release, State=0, counters 0, PCWrite=1 with idle inputs.
- Saturation: CNT_W=4, hold a stall for 20 cycles → StallCnt stops at 15.
